// File: rtl/dump_manager_fsm.sv
// Reads LEN bytes from flash starting at BASE and forwards each one to the RS transmitter.
// Latency: START->FL_RD 1 cycle, FL_STATUS->RS_SEND 1 cycle, RS_DONE->next FL_RD 2 cycles.
// Backpressure: one byte in flight; waits indefinitely on FL_STATUS and RS_DONE handshakes.
module dump_manager_fsm #(
    parameter int unsigned         ADDR_W = 24,
    parameter int unsigned         LEN    = 16,
    parameter logic [ADDR_W-1:0]   BASE   = '0
) (
    input  logic              CLK_50MHZ,
    input  logic              RST,
    input  logic              START,
    output logic              FL_RD,
    output logic [ADDR_W-1:0] FL_ADDR,
    input  logic              FL_STATUS,
    input  logic [7:0]        FL_DATA,
    output logic              RS_SEND,
    output logic [7:0]        RS_DATA,
    input  logic              RS_DONE,
    output logic              BUSY,
    output logic              DONE,
    output logic [2:0]        state
);

    localparam int unsigned        BC_W      = $clog2(LEN + 1);
    localparam logic [BC_W-1:0]    LAST_BYTE = BC_W'(LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ_FL  = 3'd1,
        S_WAIT_FL = 3'd2,
        S_SEND_RS = 3'd3,
        S_WAIT_RS = 3'd4,
        S_NEXT    = 3'd5,
        S_STOP    = 3'd6
    } state_t;

    state_t            cur_st;
    state_t            nxt_st;
    logic [ADDR_W-1:0] addr_cnt;
    logic [BC_W-1:0]   byte_cnt;
    logic [7:0]        rs_data_q;

    always_ff @(posedge CLK_50MHZ or negedge RST) begin
        if (!RST) begin
            cur_st <= S_IDLE;
        end else begin
            cur_st <= nxt_st;
        end
    end

    always_comb begin
        nxt_st = S_IDLE;
        case (cur_st)
            S_IDLE:    nxt_st = START ? S_REQ_FL : S_IDLE;
            S_REQ_FL:  nxt_st = S_WAIT_FL;
            S_WAIT_FL: nxt_st = FL_STATUS ? S_SEND_RS : S_WAIT_FL;
            S_SEND_RS: nxt_st = S_WAIT_RS;
            S_WAIT_RS: nxt_st = RS_DONE ? S_NEXT : S_WAIT_RS;
            S_NEXT:    nxt_st = (byte_cnt == LAST_BYTE) ? S_STOP : S_REQ_FL;
            S_STOP:    nxt_st = S_STOP;
            default:   nxt_st = S_IDLE;
        endcase
    end

    // Counters advance only in NEXT, so FL_ADDR stays put across the whole flash handshake.
    always_ff @(posedge CLK_50MHZ or negedge RST) begin
        if (!RST) begin
            addr_cnt  <= BASE;
            byte_cnt  <= '0;
            rs_data_q <= '0;
        end else begin
            case (cur_st)
                S_IDLE: begin
                    if (START) begin
                        addr_cnt <= BASE;
                        byte_cnt <= '0;
                    end
                end
                S_WAIT_FL: begin
                    if (FL_STATUS) begin
                        rs_data_q <= FL_DATA;
                    end
                end
                S_NEXT: begin
                    if (byte_cnt != LAST_BYTE) begin
                        addr_cnt <= addr_cnt + 1'b1;
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        FL_RD   = (cur_st == S_REQ_FL);
        RS_SEND = (cur_st == S_SEND_RS);
        BUSY    = (cur_st != S_IDLE) && (cur_st != S_STOP);
        DONE    = (cur_st == S_STOP);
        FL_ADDR = addr_cnt;
        RS_DATA = rs_data_q;
        state   = cur_st;
    end

endmodule

// File: doc/dump_manager_fsm.md
DUMP_MANAGER_FSM -- requirements
Module: dump_manager_fsm

Interface
REQ-001 Parameter ADDR_W, default 24: width of the flash byte address.
REQ-002 Parameter LEN, default 16: number of bytes per dump, legal range 1..2^ADDR_W.
REQ-003 Parameter BASE, default 0: first flash address read.
REQ-004 Port CLK_50MHZ  input  1  system clock; all state changes on its rising edge.
REQ-005 Port RST  input  1  asynchronous, active-low reset.
REQ-006 Port START  input  1  one-cycle dump request; sampled only in IDLE.
REQ-007 Port FL_RD  output  1  one-cycle flash read strobe.
REQ-008 Port FL_ADDR  output  ADDR_W  flash read address; valid while FL_RD is high and held until FL_STATUS.
REQ-009 Port FL_STATUS  input  1  one-cycle flash read-complete pulse; FL_DATA is valid in the same cycle.
REQ-010 Port FL_DATA  input  8  byte returned by flash.
REQ-011 Port RS_SEND  output  1  one-cycle transmit strobe to the RS transmitter.
REQ-012 Port RS_DATA  output  8  byte to transmit; held stable from RS_SEND until RS_DONE.
REQ-013 Port RS_DONE  input  1  one-cycle transmit-complete pulse from the RS transmitter.
REQ-014 Port BUSY  output  1  high in every state except IDLE and STOP.
REQ-015 Port DONE  output  1  high while in STOP.
REQ-016 Port state  output  3  current state encoding, for debug.

Function
REQ-017 State encoding: IDLE=0, REQ_FL=1, WAIT_FL=2, SEND_RS=3, WAIT_RS=4, NEXT=5, STOP=6.
REQ-018 IDLE -> REQ_FL when START=1. Entering REQ_FL loads the address counter with BASE and the byte counter with 0. Otherwise the FSM stays in IDLE.
REQ-019 REQ_FL: FL_RD=1 for exactly this cycle with FL_ADDR set to the address counter. Next state is unconditionally WAIT_FL.
REQ-020 WAIT_FL: FL_STATUS=1 captures FL_DATA into the RS_DATA register and moves to SEND_RS. Otherwise the FSM stays in WAIT_FL, with no timeout.
REQ-021 SEND_RS: RS_SEND=1 for exactly this cycle. Next state is unconditionally WAIT_RS.
REQ-022 WAIT_RS: RS_DONE=1 moves to NEXT. Otherwise the FSM stays in WAIT_RS.
REQ-023 NEXT: if the byte counter equals LEN-1, go to STOP. Otherwise increment both counters and go to REQ_FL.
REQ-024 STOP: the FSM holds until reset; START is ignored.
REQ-025 The address counter is ADDR_W bits and wraps modulo 2^ADDR_W without error.
REQ-026 The byte counter is $clog2(LEN+1) bits and never exceeds LEN-1.
REQ-027 Latency from START to the first FL_RD is 1 cycle. Latency from FL_STATUS to RS_SEND is 1 cycle. Latency from RS_DONE to the next FL_RD is 2 cycles.
REQ-028 FL_STATUS outside WAIT_FL and RS_DONE outside WAIT_RS are ignored and have no side effects.
REQ-029 START asserted while BUSY=1 is ignored.
REQ-030 FL_RD and RS_SEND are never high in the same cycle. Neither strobe is ever high for two consecutive cycles.
REQ-031 Exactly LEN RS_SEND pulses are issued per dump, in ascending address order.
REQ-032 Next-state and strobe logic is combinational, with a defined default for every path and no latches. Unused encodings 7 go to IDLE.

Reset
REQ-033 While RST=0, independent of the clock: state=IDLE, FL_RD=0, RS_SEND=0, FL_ADDR=BASE, RS_DATA=0, BUSY=0, DONE=0, both counters 0.
REQ-034 Reset asserted mid-dump aborts immediately with no further strobes. After release, the block waits for a new START.
REQ-035 On the first clock edge after reset release, the block evaluates START normally.

Verification
REQ-036 LEN=4, BASE=0, flash returns addr+0x10 two cycles after each FL_RD, RS_DONE 5 cycles after each RS_SEND -> RS_DATA sequence 0x10,0x11,0x12,0x13; DONE=1 after the 4th RS_DONE; exactly 4 FL_RD and 4 RS_SEND.
REQ-037 START pulse with FL_STATUS withheld for 1000 cycles -> FSM remains in WAIT_FL (state=2), BUSY=1, no RS_SEND; normal completion once FL_STATUS arrives.
REQ-038 Spurious FL_STATUS in WAIT_RS and spurious RS_DONE in WAIT_FL -> no state change, RS_DATA unchanged, byte count unaffected.
REQ-039 BASE=2^ADDR_W-2, LEN=4 -> FL_ADDR sequence 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001.
REQ-040 RST pulled low in WAIT_RS of byte 2 -> all outputs at reset values within the same cycle; a new START restarts from BASE with byte count 0.
REQ-041 Second START during a dump and START in STOP -> ignored; total RS_SEND count remains LEN.
